izh_spike_analyzer: RTL and testbench
=====================================

# izh_spike_analyzer

Downstream consumer of the Izhikevich neuron core's membrane-voltage byte (integer part of v, signed 8-bit). It detects spikes with a hysteresis state machine and emits a one-cycle spike pulse. It keeps a saturating spike count and measures inter-spike intervals (ISIs) in neuron-update samples. ISIs are buffered in a small FIFO and read out over a valid/ready handshake to the host or logging stage.

## Interface
- THRESH, 30: signed 8-bit spike threshold; spike when v_in >= THRESH while ARMED
- REARM, 0: signed 8-bit re-arm level; v_in < REARM returns FSM to ARMED; must be < THRESH
- ISI_W, 16: ISI counter/data width
- DEPTH, 8: FIFO depth, power of two, >= 2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- v_in  in  8  signed membrane voltage integer part from neuron core
- sample_en  in  1  high on cycles where v_in is a new neuron sample (neuron ena)
- clear  in  1  synchronous soft clear (same effect as reset, lower priority than rst_n)
- spike_pulse  out  1  one-cycle pulse per detected spike
- spike_count  out  16  saturating spike total
- isi_data  out  ISI_W  FIFO head ISI, valid when isi_valid
- isi_valid  out  1  FIFO non-empty
- isi_ready  in  1  consumer accepts head when isi_valid && isi_ready
- fifo_level  out  log2(DEPTH)+1  entries stored
- overflow  out  1  sticky: an ISI was dropped because FIFO was full

## Operation
- FSM states: REFRACT, ARMED. Reset/clear -> REFRACT. Transitions evaluated only when sample_en=1.
- REFRACT: v_in < REARM (signed compare) -> ARMED; else stay.
- ARMED: v_in >= THRESH -> spike sample; go REFRACT. Else stay.
- All v_in comparisons signed 8-bit; -128 and +127 legal.
- ISI counter isi_cnt: on a non-spike sample, isi_cnt <= isi_cnt+1, saturating at 2^ISI_W-1. On a spike sample, candidate ISI = isi_cnt+1 (saturating), then isi_cnt <= 0.
- have_ref flag: cleared by reset/clear, set on first spike. First spike after reset/clear pushes nothing (no reference), but pulses spike_pulse and counts.
- Push: spike sample with have_ref=1. Accepted if level < DEPTH, or level = DEPTH and a pop occurs the same cycle. Otherwise dropped; overflow <= 1.
- Pop: isi_valid && isi_ready. Simultaneous push+pop: level unchanged, order preserved (FIFO strict order).
- spike_count increments per spike, saturates at 16'hFFFF.
- Samples with sample_en=0 are ignored entirely: no FSM change, no count.
- rst_n low: all state cleared regardless of clear. clear high: identical effect, FIFO contents discarded; a pop/push in that cycle is discarded.

## Timing
- Reset values: spike_pulse=0, spike_count=0, isi_valid=0, isi_data=0, fifo_level=0, overflow=0. FSM=REFRACT, isi_cnt=0, have_ref=0.
- Spike sample at edge N: spike_pulse high for cycle after N only, spike_count updated after N.
- Push at edge N: isi_valid=1, fifo_level, and isi_data (if previously empty) visible after N; 1-cycle latency.
- Pop at edge N: next head on isi_data after N; isi_valid drops after N if emptied.
- isi_data is stable while isi_valid && !isi_ready.
- Fully synchronous; no combinational path from isi_ready to isi_valid/isi_data.

## Test plan
- Reset: rst_n low 2 cycles with v_in=50, sample_en=1 -> all outputs 0; no spike until v_in < 0 seen, then v_in=30 -> spike_pulse one cycle, spike_count=1, isi_valid stays 0.
- Hysteresis: ARMED, v_in sequence -65,31,29,31,-1,35 -> exactly 2 spikes (at 31 and 35); 29/31 in refract ignored.
- ISI: spikes on samples 0 and 10 (-65 elsewhere), isi_ready=0 -> isi_data=10, fifo_level=1. Repeat with sample_en low on alternate cycles -> still 10.
- Saturation: ISI_W=4, 20 samples between spikes -> isi_data=15.
- Full/overflow: 9 ISIs pushed, DEPTH=8, isi_ready=0 -> level=8, overflow=1, heads are first 8 in order. Then push with isi_ready=1 on a full FIFO -> accepted, level stays 8, overflow unchanged.
- Clear mid-operation: FIFO with 3 entries, clear pulse -> level=0, isi_valid=0, overflow=0, spike_count=0. Next spike pushes nothing.

Source files
------------

// File: rtl/izh_spike_analyzer.sv
// Spike detector for the Izhikevich membrane-voltage byte: hysteresis FSM, saturating
// spike count, inter-spike-interval measurement and an ISI FIFO with valid/ready readout.
module izh_spike_analyzer #(
  parameter logic signed [7:0] THRESH = 8'sd30,
  parameter logic signed [7:0] REARM  = 8'sd0,
  parameter int unsigned       ISI_W  = 16,
  parameter int unsigned       DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [7:0]          v_in,
  input  logic                       sample_en,
  input  logic                       clear,
  output logic                       spike_pulse,
  output logic [15:0]                spike_count,
  output logic [ISI_W-1:0]           isi_data,
  output logic                       isi_valid,
  input  logic                       isi_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  localparam logic [15:0]      CNT_MAX = '1;

  typedef enum logic {REFRACT = 1'b0, ARMED = 1'b1} state_t;

  state_t            state_q;
  logic [ISI_W-1:0]  isi_cnt_q;
  logic              have_ref_q;
  logic              spike_pulse_q;
  logic [15:0]       spike_count_q;
  logic              overflow_q;
  logic [ISI_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic              valid_q;

  logic              spike_c;
  logic [ISI_W-1:0]  isi_inc_c;
  logic              pop_c;
  logic              push_req_c;
  logic              push_c;

  // Spike decision, saturating ISI increment and FIFO handshake
  always_comb begin
    spike_c    = sample_en && (state_q == ARMED) && (v_in >= THRESH);
    isi_inc_c  = (isi_cnt_q == ISI_MAX) ? isi_cnt_q : isi_cnt_q + ISI_W'(1);
    pop_c      = valid_q && isi_ready;
    push_req_c = spike_c && have_ref_q;
    push_c     = push_req_c && ((level_q != LW'(DEPTH)) || pop_c);
    level_d    = level_q;
    if (push_c && !pop_c) begin
      level_d = level_q + LW'(1);
    end else if (pop_c && !push_c) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q       <= REFRACT;
      isi_cnt_q     <= '0;
      have_ref_q    <= 1'b0;
      spike_pulse_q <= 1'b0;
      spike_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      level_q       <= '0;
      valid_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // Hysteresis FSM; only real neuron samples advance it
      if (sample_en) begin
        case (state_q)
          REFRACT: if (v_in < REARM) state_q <= ARMED;
          ARMED:   if (spike_c) state_q <= REFRACT;
          default: state_q <= REFRACT;
        endcase
        isi_cnt_q <= spike_c ? '0 : isi_inc_c;
      end
      spike_pulse_q <= spike_c;
      if (spike_c) begin
        have_ref_q <= 1'b1;
        if (spike_count_q != CNT_MAX) spike_count_q <= spike_count_q + 16'd1;
      end
      if (push_req_c && !push_c) overflow_q <= 1'b1;
      // On a full FIFO with a pop, wr_q == rd_q: the write replaces the departing head
      if (push_c) begin
        mem_q[wr_q] <= isi_inc_c;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_c) rd_q <= rd_q + AW'(1);
      level_q <= level_d;
      valid_q <= (level_d != '0);
    end
  end

  assign spike_pulse = spike_pulse_q;
  assign spike_count = spike_count_q;
  assign overflow    = overflow_q;
  assign isi_valid   = valid_q;
  assign isi_data    = mem_q[rd_q];
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_izh_spike_analyzer.sv
// Directed bench for izh_spike_analyzer: expected ISIs go into a queue that a
// negedge monitor checks against the FIFO head; status outputs checked inline.
module tb_izh_spike_analyzer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [7:0]  v_in;
  logic               sample_en;
  logic               clear;
  logic               isi_ready;

  logic               spike_pulse;
  logic [15:0]        spike_count;
  logic [15:0]        isi_data;
  logic               isi_valid;
  logic [3:0]         fifo_level;
  logic               overflow;

  logic               s_spike_pulse;
  logic [15:0]        s_spike_count;
  logic [3:0]         s_isi_data;
  logic               s_isi_valid;
  logic [3:0]         s_fifo_level;
  logic               s_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  izh_spike_analyzer u_dut (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .sample_en(sample_en), .clear(clear),
    .spike_pulse(spike_pulse), .spike_count(spike_count), .isi_data(isi_data),
    .isi_valid(isi_valid), .isi_ready(isi_ready), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  izh_spike_analyzer #(.ISI_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .sample_en(sample_en), .clear(clear),
    .spike_pulse(s_spike_pulse), .spike_count(s_spike_count), .isi_data(s_isi_data),
    .isi_valid(s_isi_valid), .isi_ready(1'b0), .fifo_level(s_fifo_level),
    .overflow(s_overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: head must match oldest expected ISI; pop on handshake
  always @(negedge clk) begin
    if (rst_n && !clear && isi_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL isi_head: got %0d with nothing expected (t=%0t)", isi_data, $time);
      end else begin
        chk("isi_head", int'(isi_data), exp_q[0]);
        if (isi_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic samp(input logic signed [7:0] v);
    v_in = v;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    sample_en = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    sample_en = 1'b0;
    isi_ready = 1'b1;
    for (int i = 0; i < 40 && isi_valid; i++) begin
      @(posedge clk); #1;
    end
    isi_ready = 1'b0;
    chk("drain_valid", int'(isi_valid), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; isi_ready = 1'b0;
    v_in = 8'sd50; sample_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", int'(spike_pulse), 0);
    chk("rst_count", int'(spike_count), 0);
    chk("rst_valid", int'(isi_valid), 0);
    chk("rst_data", int'(isi_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;

    // Starts refractory: 50 is ignored until a sub-REARM sample arms it
    samp(8'sd50);
    chk("refract_pulse", int'(spike_pulse), 0);
    samp(-8'sd1);
    samp(8'sd30);
    chk("first_pulse", int'(spike_pulse), 1);
    chk("first_count", int'(spike_count), 1);
    samp(-8'sd65);
    chk("pulse_one_cycle", int'(spike_pulse), 0);
    chk("first_no_push", int'(isi_valid), 0);

    // Hysteresis: -65,31,29,31,-1,35 -> spikes at 31 (ISI 3) and 35 (ISI 4)
    samp(-8'sd65);
    exp_q.push_back(3);
    samp(8'sd31);
    chk("hyst_pulse1", int'(spike_pulse), 1);
    chk("hyst_count1", int'(spike_count), 2);
    samp(8'sd29);
    samp(8'sd31);
    chk("hyst_refract31", int'(spike_pulse), 0);
    samp(-8'sd1);
    exp_q.push_back(4);
    samp(8'sd35);
    chk("hyst_pulse2", int'(spike_pulse), 1);
    chk("hyst_count2", int'(spike_count), 3);
    chk("hyst_level", int'(fifo_level), 2);
    drain();

    // ISI of 10 samples, then again with idle cycles interleaved
    do_clear();
    samp(-8'sd65);
    samp(8'sd40);
    for (int i = 0; i < 9; i++) samp(-8'sd65);
    exp_q.push_back(10);
    samp(8'sd40);
    chk("isi10_level", int'(fifo_level), 1);
    chk("isi10_data", int'(isi_data), 10);
    for (int i = 0; i < 9; i++) begin
      samp(-8'sd65);
      v_in = 8'sd40;
      idle(1);
    end
    exp_q.push_back(10);
    samp(8'sd40);
    chk("isi10_gap_level", int'(fifo_level), 2);
    drain();

    // ISI saturation in the 4-bit instance: 21 samples -> 15
    do_clear();
    samp(-8'sd65);
    samp(8'sd40);
    for (int i = 0; i < 20; i++) samp(-8'sd65);
    exp_q.push_back(21);
    samp(8'sd40);
    chk("sat_valid", int'(s_isi_valid), 1);
    chk("sat_data", int'(s_isi_data), 15);
    drain();

    // Full FIFO: 9 ISIs (2..10), ninth dropped
    do_clear();
    samp(-8'sd65);
    samp(8'sd40);
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < k; j++) samp(-8'sd65);
      if (k <= 8) exp_q.push_back(k + 1);
      samp(8'sd40);
    end
    chk("full_level", int'(fifo_level), 8);
    chk("full_ovf", int'(overflow), 1);
    chk("full_head", int'(isi_data), 2);
    // Push on full with a simultaneous pop is accepted
    samp(-8'sd65);
    samp(-8'sd65);
    exp_q.push_back(3);
    isi_ready = 1'b1;
    samp(8'sd40);
    isi_ready = 1'b0;
    chk("fullpp_level", int'(fifo_level), 8);
    chk("fullpp_ovf", int'(overflow), 1);
    chk("fullpp_head", int'(isi_data), 3);
    drain();

    // Clear mid-operation with 3 entries queued
    do_clear();
    samp(-8'sd65);
    samp(8'sd40);
    for (int k = 0; k < 3; k++) begin
      samp(-8'sd65);
      exp_q.push_back(2);
      samp(8'sd40);
    end
    chk("pre_clear_level", int'(fifo_level), 3);
    chk("pre_clear_count", int'(spike_count), 4);
    do_clear();
    chk("clr_level", int'(fifo_level), 0);
    chk("clr_valid", int'(isi_valid), 0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_count", int'(spike_count), 0);
    samp(-8'sd65);
    samp(8'sd40);
    chk("clr_spike_count", int'(spike_count), 1);
    chk("clr_no_push", int'(isi_valid), 0);
    chk("clr_no_level", int'(fifo_level), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
